// File: rtl/spatz_pkg.sv
// Shared Spatz VRF types plus the writer indices that vrf_wid_o reports.
package spatz_pkg;

  typedef logic [4:0]  vreg_addr_t;
  typedef logic [31:0] vreg_data_t;
  typedef logic [3:0]  vreg_be_t;

  localparam int NrVrfWriters = 3;

  typedef enum logic [1:0] {
    VFU  = 2'd0,
    VLSU = 2'd1,
    VSLD = 2'd2
  } vrf_writer_e;

endpackage

// File: rtl/spatz_vrf_warb_if.sv
// Bundle between the VRF writers, the write-port arbiter and one VRF write port.
interface spatz_vrf_warb_if #(
  parameter int NrReq = 3
) ();
  import spatz_pkg::*;

  localparam int IdWidth = $clog2(NrReq);

  logic       [NrReq-1:0] req_valid_i;
  logic       [NrReq-1:0] req_ready_o;
  logic       [NrReq-1:0] req_lock_i;
  vreg_addr_t [NrReq-1:0] req_addr_i;
  vreg_data_t [NrReq-1:0] req_data_i;
  vreg_be_t   [NrReq-1:0] req_be_i;

  logic                   vrf_we_o;
  logic                   vrf_wvalid_i;
  vreg_addr_t             vrf_waddr_o;
  vreg_data_t             vrf_wdata_o;
  vreg_be_t               vrf_wbe_o;
  logic     [IdWidth-1:0] vrf_wid_o;
  logic                   busy_o;

  modport master (
    output req_valid_i, req_lock_i, req_addr_i, req_data_i, req_be_i, vrf_wvalid_i,
    input  req_ready_o, vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_wid_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_lock_i, req_addr_i, req_data_i, req_be_i, vrf_wvalid_i,
    output req_ready_o, vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_wid_o, busy_o
  );

endinterface

// File: rtl/spatz_rr_pick.sv
// Combinational rotate-priority picker: first valid at or above ptr, wrapping.
module spatz_rr_pick #(
  parameter int NrReq   = 3,
  parameter int IdWidth = $clog2(NrReq)
) (
  input  logic [NrReq-1:0]   valid,
  input  logic [IdWidth-1:0] ptr,
  output logic [NrReq-1:0]   grant,
  output logic [IdWidth-1:0] idx,
  output logic               found
);

  logic [IdWidth-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NrReq; k++) begin
      pos = IdWidth'((int'(ptr) + k) % NrReq);
      if (!found && valid[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/spatz_vrf_warb.sv
// Round-robin VRF write-port arbiter with burst lock and one registered output beat.
module spatz_vrf_warb
  import spatz_pkg::*;
#(
  parameter int NrReq = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spatz_vrf_warb_if.slave bus
);

  localparam int IdWidth = $clog2(NrReq);

  localparam logic [0:0] LockIdle = 1'b0;
  localparam logic [0:0] LockHeld = 1'b1;

  logic               out_valid_q;
  vreg_addr_t         addr_q;
  vreg_data_t         data_q;
  vreg_be_t           be_q;
  logic [IdWidth-1:0] id_q;
  logic [IdWidth-1:0] rr_ptr_q;
  logic [IdWidth-1:0] lock_id_q;
  logic [0:0]         lock_q;

  logic               space;
  logic               accept;
  logic               found;
  logic [NrReq-1:0]   lock_mask;
  logic [NrReq-1:0]   pick_valid;
  logic [NrReq-1:0]   grant;
  logic [IdWidth-1:0] pick_idx;

  assign space     = !out_valid_q || bus.vrf_wvalid_i;
  assign lock_mask = {{(NrReq-1){1'b0}}, 1'b1} << lock_id_q;

  // While a burst lock is held only its owner is visible to the picker.
  assign pick_valid = (lock_q == LockHeld) ? (bus.req_valid_i & lock_mask) : bus.req_valid_i;

  spatz_rr_pick #(
    .NrReq   (NrReq),
    .IdWidth (IdWidth)
  ) i_pick (
    .valid (pick_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (pick_idx),
    .found (found)
  );

  assign accept          = found & space & !rst_i;
  assign bus.req_ready_o = grant & {NrReq{accept}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= LockIdle;
      lock_id_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      addr_q      <= bus.req_addr_i[pick_idx];
      data_q      <= bus.req_data_i[pick_idx];
      be_q        <= bus.req_be_i[pick_idx];
      id_q        <= pick_idx;
      rr_ptr_q    <= (pick_idx == IdWidth'(NrReq - 1)) ? '0 : pick_idx + 1'b1;
      lock_q      <= bus.req_lock_i[pick_idx] ? LockHeld : LockIdle;
      lock_id_q   <= pick_idx;
    end else if (bus.vrf_wvalid_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.vrf_we_o    = out_valid_q;
  assign bus.vrf_waddr_o = addr_q;
  assign bus.vrf_wdata_o = data_q;
  assign bus.vrf_wbe_o   = be_q;
  assign bus.vrf_wid_o   = id_q;
  assign bus.busy_o      = out_valid_q | (lock_q == LockHeld);

  a_min_req: assert property (@(posedge clk_i) NrReq >= 2)
    else $error("spatz_vrf_warb needs at least two requesters");

  a_onehot_ready: assert property (@(posedge clk_i) $onehot0(bus.req_ready_o))
    else $error("more than one req_ready_o set");

  a_stable_payload: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_q && !bus.vrf_wvalid_i) |=>
      (out_valid_q && $stable(addr_q) && $stable(data_q) && $stable(be_q) && $stable(id_q)))
    else $error("buffered beat changed under backpressure");

endmodule

// File: tb/tb_spatz_vrf_warb.sv
// Directed bench for the VRF write-port arbiter: rr order, backpressure, lock, wrap, reset, idle.
module tb_spatz_vrf_warb;
  import spatz_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spatz_vrf_warb_if #(.NrReq(3)) bus ();

  spatz_vrf_warb #(.NrReq(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vreg_addr_t exp_addr(input logic [1:0] i);
    return 5'd8 + 5'(i);
  endfunction

  function automatic vreg_data_t exp_data(input logic [1:0] i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic v, input logic l);
    bus.req_valid_i[i] = v;
    bus.req_lock_i[i]  = l;
    bus.req_addr_i[i]  = exp_addr(i);
    bus.req_data_i[i]  = exp_data(i);
    bus.req_be_i[i]    = 4'hF;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 3; i++) set_req(2'(i), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(2'd0, 1'b1, 1'b0);
    bus.vrf_wvalid_i = 1'b1;
    repeat (2) tick();
    if (bus.vrf_we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", bus.vrf_we_o); end
    checks++;
    if (bus.vrf_waddr_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", bus.vrf_waddr_o); end
    checks++;
    if (bus.vrf_wid_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_wid got %0d want 0", bus.vrf_wid_o); end
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy_o); end
    checks++;
    if (bus.req_ready_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready got %b want 000", bus.req_ready_o); end
    checks++;
    rst = 1'b0;
    clear_reqs();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 3; i++) set_req(2'(i), 1'b1, 1'b0);
    bus.vrf_wvalid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] g;
      logic [2:0] want;
      g    = 2'(k % 3);
      want = 3'b001 << g;
      #1;
      if (bus.req_ready_o !== want) begin errors++; $display("[TB] FAIL rr_ready k=%0d got %b want %b", k, bus.req_ready_o, want); end
      checks++;
      tick();
      if (bus.vrf_we_o !== 1'b1) begin errors++; $display("[TB] FAIL rr_we k=%0d got %b want 1", k, bus.vrf_we_o); end
      checks++;
      if (bus.vrf_wid_o !== g) begin errors++; $display("[TB] FAIL rr_wid k=%0d got %0d want %0d", k, bus.vrf_wid_o, g); end
      checks++;
      if (bus.vrf_waddr_o !== exp_addr(g)) begin errors++; $display("[TB] FAIL rr_addr k=%0d got %0d want %0d", k, bus.vrf_waddr_o, exp_addr(g)); end
      checks++;
    end
    clear_reqs();
    tick();
    if (bus.vrf_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rr_drain_we got %b want 0", bus.vrf_we_o); end
    checks++;
  endtask

  task automatic test_backpressure();
    set_req(2'd0, 1'b1, 1'b0);
    bus.req_addr_i[0] = 5'd5;
    bus.req_data_i[0] = 32'hA5;
    bus.vrf_wvalid_i  = 1'b0;
    #1;
    if (bus.req_ready_o !== 3'b001) begin errors++; $display("[TB] FAIL bp_first_ready got %b want 001", bus.req_ready_o); end
    checks++;
    tick();
    bus.req_addr_i[0] = 5'd6;
    bus.req_data_i[0] = 32'h66;
    set_req(2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus.req_ready_o !== 3'b000) begin errors++; $display("[TB] FAIL bp_stall_ready k=%0d got %b want 000", k, bus.req_ready_o); end
      checks++;
      if (bus.vrf_we_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall_we k=%0d got %b want 1", k, bus.vrf_we_o); end
      checks++;
      if (bus.vrf_waddr_o !== 5'd5 || bus.vrf_wdata_o !== 32'hA5) begin
        errors++; $display("[TB] FAIL bp_stall_payload k=%0d got %0d/%h want 5/a5", k, bus.vrf_waddr_o, bus.vrf_wdata_o);
      end
      checks++;
      tick();
    end
    bus.vrf_wvalid_i = 1'b1;
    #1;
    if (bus.req_ready_o !== 3'b010) begin errors++; $display("[TB] FAIL bp_refill_ready got %b want 010", bus.req_ready_o); end
    checks++;
    tick();
    if (bus.vrf_we_o !== 1'b1 || bus.vrf_wid_o !== 2'd1) begin
      errors++; $display("[TB] FAIL bp_refill_out got we=%b wid=%0d want we=1 wid=1", bus.vrf_we_o, bus.vrf_wid_o);
    end
    checks++;
    if (bus.vrf_waddr_o !== exp_addr(2'd1)) begin errors++; $display("[TB] FAIL bp_refill_addr got %0d want %0d", bus.vrf_waddr_o, exp_addr(2'd1)); end
    checks++;
    clear_reqs();
    tick();
    if (bus.vrf_we_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_we got %b want 0", bus.vrf_we_o); end
    checks++;
  endtask

  task automatic test_burst_lock();
    set_req(2'd0, 1'b1, 1'b0);
    #1;
    if (bus.req_ready_o !== 3'b001) begin errors++; $display("[TB] FAIL lock_setup_ready got %b want 001", bus.req_ready_o); end
    checks++;
    tick();
    set_req(2'd0, 1'b1, 1'b0);
    set_req(2'd1, 1'b1, 1'b1);
    set_req(2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) set_req(2'd1, 1'b1, 1'b0);
      #1;
      if (bus.req_ready_o !== 3'b010) begin errors++; $display("[TB] FAIL lock_beat_ready k=%0d got %b want 010", k, bus.req_ready_o); end
      checks++;
      tick();
      if (bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL lock_beat_busy k=%0d got %b want 1", k, bus.busy_o); end
      checks++;
    end
    #1;
    if (bus.req_ready_o !== 3'b100) begin errors++; $display("[TB] FAIL lock_release_ready got %b want 100", bus.req_ready_o); end
    checks++;
    tick();
    clear_reqs();
    set_req(2'd1, 1'b1, 1'b1);
    #1;
    if (bus.req_ready_o !== 3'b010) begin errors++; $display("[TB] FAIL lock_open_ready got %b want 010", bus.req_ready_o); end
    checks++;
    tick();
    clear_reqs();
    set_req(2'd0, 1'b1, 1'b0);
    set_req(2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus.req_ready_o !== 3'b000) begin errors++; $display("[TB] FAIL lock_hold_ready k=%0d got %b want 000", k, bus.req_ready_o); end
      checks++;
      tick();
    end
    if (bus.vrf_we_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++; $display("[TB] FAIL lock_hold_state got we=%b busy=%b want we=0 busy=1", bus.vrf_we_o, bus.busy_o);
    end
    checks++;
    set_req(2'd1, 1'b1, 1'b0);
    #1;
    if (bus.req_ready_o !== 3'b010) begin errors++; $display("[TB] FAIL lock_resume_ready got %b want 010", bus.req_ready_o); end
    checks++;
    tick();
    clear_reqs();
    tick();
    if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL lock_end_busy got %b want 0", bus.busy_o); end
    checks++;
  endtask

  task automatic test_wrap();
    logic [2:0] want [3];
    want[0] = 3'b100;
    want[1] = 3'b001;
    want[2] = 3'b100;
    set_req(2'd0, 1'b1, 1'b0);
    set_req(2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus.req_ready_o !== want[k]) begin errors++; $display("[TB] FAIL wrap_ready k=%0d got %b want %b", k, bus.req_ready_o, want[k]); end
      checks++;
      tick();
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(2'd2, 1'b1, 1'b1);
    bus.vrf_wvalid_i = 1'b0;
    #1;
    if (bus.req_ready_o !== 3'b100) begin errors++; $display("[TB] FAIL rstmid_ready got %b want 100", bus.req_ready_o); end
    checks++;
    tick();
    if (bus.vrf_we_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_pre got we=%b busy=%b want 1/1", bus.vrf_we_o, bus.busy_o);
    end
    checks++;
    rst = 1'b1;
    clear_reqs();
    tick();
    if (bus.vrf_we_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_post got we=%b busy=%b want 0/0", bus.vrf_we_o, bus.busy_o);
    end
    checks++;
    if (bus.vrf_waddr_o !== 5'd0) begin errors++; $display("[TB] FAIL rstmid_addr got %0d want 0", bus.vrf_waddr_o); end
    checks++;
    rst = 1'b0;
    bus.vrf_wvalid_i = 1'b1;
    set_req(2'd1, 1'b1, 1'b1);
    set_req(2'd2, 1'b1, 1'b0);
    #1;
    if (bus.req_ready_o !== 3'b010) begin errors++; $display("[TB] FAIL rstmid_next_ready got %b want 010", bus.req_ready_o); end
    checks++;
    tick();
  endtask

  task automatic test_idle();
    clear_reqs();
    repeat (10) tick();
    if (bus.vrf_we_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++; $display("[TB] FAIL idle_state got we=%b busy=%b want we=0 busy=1", bus.vrf_we_o, bus.busy_o);
    end
    checks++;
    set_req(2'd0, 1'b1, 1'b0);
    set_req(2'd2, 1'b1, 1'b0);
    #1;
    if (bus.req_ready_o !== 3'b000) begin errors++; $display("[TB] FAIL idle_lock_ready got %b want 000", bus.req_ready_o); end
    checks++;
    set_req(2'd1, 1'b1, 1'b0);
    #1;
    if (bus.req_ready_o !== 3'b010) begin errors++; $display("[TB] FAIL idle_owner_ready got %b want 010", bus.req_ready_o); end
    checks++;
    tick();
    set_req(2'd1, 1'b0, 1'b0);
    #1;
    if (bus.req_ready_o !== 3'b100) begin errors++; $display("[TB] FAIL idle_ptr_ready got %b want 100", bus.req_ready_o); end
    checks++;
    tick();
    clear_reqs();
    tick();
  endtask

  initial begin
    clear_reqs();
    bus.vrf_wvalid_i = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_burst_lock();
    test_wrap();
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
